// File: rtl/chip_checker_pkg.sv
// Types and helpers used by the chip_* pin testers: checker state encoding,
// SH/LD' pin levels and the JK' next-QA rule of the 74195 family.
package chip_checker_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, SETUP, CLK_HI, CLK_LO, CHECK, DONE_S} state_e;

  localparam logic SHLD_LOAD  = 1'b0;
  localparam logic SHLD_SHIFT = 1'b1;

  function automatic logic jk_next(input logic j, input logic kn, input logic qa);
    case ({j, kn})
      2'b00:   jk_next = 1'b0;
      2'b11:   jk_next = 1'b1;
      2'b01:   jk_next = qa;
      default: jk_next = ~qa;
    endcase
  endfunction

endpackage

// File: rtl/shreg_model.sv
// Golden model of a parallel-access JK-input shift register (74195 family).
// clr_i zeroes the register; step_i applies one chip clock with the given pins.
module shreg_model
  import chip_checker_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             step_i,
  input  logic             shld_n_i,
  input  logic             j_i,
  input  logic             kn_i,
  input  logic [WIDTH-1:0] par_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (step_i) begin
      if (shld_n_i == SHLD_LOAD) q_d = par_i;
      else                       q_d = {q_q[WIDTH-2:0], jk_next(j_i, kn_i, q_q[0])};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/shreg_chip_checker.sv
// Pin sequencer and checker for 74195-style shift-register parts.
// Define SHREG_FAIL_CAPTURE_EN to expose FAIL_IDX/FAIL_EXP/FAIL_OBS.
module shreg_chip_checker
  import chip_checker_pkg::*;
#(
  parameter int  WIDTH         = 4,
  parameter int  SETTLE_CYCLES = 8,
  parameter int  NUM_VECTORS   = 2**(WIDTH+3),
  localparam int VW            = $clog2(NUM_VECTORS) + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             DISP_RSLT,
  output logic             CLR_N_OUT,
  output logic             SHLD_N_OUT,
  output logic             J_OUT,
  output logic             KN_OUT,
  output logic [WIDTH-1:0] PAR_OUT,
  output logic             CHIP_CLK,
  input  logic [WIDTH-1:0] Q_IN,
  input  logic             QN_IN,
  output logic             Done,
  output logic             RSLT
`ifdef SHREG_FAIL_CAPTURE_EN
  ,
  output logic [VW-1:0]    FAIL_IDX,
  output logic [WIDTH:0]   FAIL_EXP,
  output logic [WIDTH:0]   FAIL_OBS
`endif
);

  localparam int SW = WIDTH + 3;
  localparam int DW = $clog2(SETTLE_CYCLES) + 1;

  state_e            state_q, state_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [VW-1:0]     vec_q, vec_d;
  logic              fail_q, fail_d;
  logic              run_q;
  logic [1:0][WIDTH:0] q_sync_q;
  logic [SW-1:0]     stim;
  logic [WIDTH-1:0]  model_q;
  logic [WIDTH:0]    exp_v;
  logic              dwell_done, mism, drive, step, clr;

  generate
    if (SW <= VW) begin : g_stim_trunc
      assign stim = vec_q[SW-1:0];
    end else begin : g_stim_ext
      assign stim = {{(SW-VW){1'b0}}, vec_q};
    end
  endgenerate

  assign exp_v      = {~model_q[WIDTH-1], model_q};
  assign mism       = q_sync_q[1] != exp_v;
  assign dwell_done = dwell_q == DW'(SETTLE_CYCLES - 1);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    fail_d  = fail_q;
    step    = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        vec_d = '0;
        if (Run && !run_q) state_d = CLEAR;
      end
      CLEAR: begin
        clr = 1'b1;
        if (dwell_done) state_d = SETUP;
      end
      SETUP: if (dwell_done) begin
        // Clear vector is judged here: the chip is unclocked since CLEAR and the
        // input synchroniser has had time to deliver the cleared outputs.
        if (vec_q == '0 && mism) begin
          fail_d  = 1'b1;
          state_d = DONE_S;
        end else begin
          step    = 1'b1;
          state_d = CLK_HI;
        end
      end
      CLK_HI: if (dwell_done) state_d = CLK_LO;
      CLK_LO: if (dwell_done) state_d = CHECK;
      CHECK: begin
        if (mism) begin
          fail_d  = 1'b1;
          state_d = DONE_S;
        end else if (vec_q == VW'(NUM_VECTORS - 1)) begin
          state_d = DONE_S;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = SETUP;
        end
      end
      DONE_S: if (DISP_RSLT && !Run) begin
        fail_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dwell_d = (state_d != state_q) ? '0 : dwell_q + 1'b1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      dwell_q  <= '0;
      vec_q    <= '0;
      fail_q   <= 1'b0;
      run_q    <= 1'b0;
      q_sync_q <= '0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      vec_q    <= vec_d;
      fail_q   <= fail_d;
      run_q    <= Run;
      q_sync_q <= {q_sync_q[0], {QN_IN, Q_IN}};
    end
  end

  shreg_model #(.WIDTH(WIDTH)) u_model (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .clr_i   (clr),
    .step_i  (step),
    .shld_n_i(stim[0]),
    .j_i     (stim[2]),
    .kn_i    (stim[1]),
    .par_i   (stim[SW-1:3]),
    .q_o     (model_q)
  );

  // Pins decode straight from state so reset parks them asynchronously.
  assign drive      = state_q inside {SETUP, CLK_HI, CLK_LO, CHECK};
  assign CLR_N_OUT  = state_q != CLEAR;
  assign SHLD_N_OUT = drive ? stim[0] : SHLD_SHIFT;
  assign KN_OUT     = drive & stim[1];
  assign J_OUT      = drive & stim[2];
  assign PAR_OUT    = drive ? stim[SW-1:3] : '0;
  assign CHIP_CLK   = state_q == CLK_HI;
  assign Done       = state_q == DONE_S;
  assign RSLT       = Done & ~fail_q;

`ifdef SHREG_FAIL_CAPTURE_EN
  logic [VW-1:0]  fail_idx_q;
  logic [WIDTH:0] fail_exp_q, fail_obs_q;
  logic           cap_en, idle_entry;

  assign cap_en     = fail_d && !fail_q;
  assign idle_entry = state_q == DONE_S && state_d == IDLE;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fail_idx_q <= '0;
      fail_exp_q <= '0;
      fail_obs_q <= '0;
    end else if (cap_en) begin
      fail_idx_q <= vec_q;
      fail_exp_q <= exp_v;
      fail_obs_q <= q_sync_q[1];
    end else if (idle_entry) begin
      fail_idx_q <= '0;
      fail_exp_q <= '0;
      fail_obs_q <= '0;
    end
  end

  assign FAIL_IDX = fail_idx_q;
  assign FAIL_EXP = fail_exp_q;
  assign FAIL_OBS = fail_obs_q;
`endif

endmodule

// File: tb/tb_shreg_chip_checker.sv
// Scoreboarded bench: behavioural 74195-style chips on the pins of two checkers
// (WIDTH=4/128 vectors and WIDTH=8/16 vectors), monitors compare Done/RSLT/latency.
module tb_shreg_chip_checker;

  localparam int S   = 2;
  localparam int NV1 = 128;
  localparam int NV2 = 16;

  typedef struct {bit rslt; int lat;} exp_t;

  logic Clk = 0, Reset = 0;
  logic run1 = 0, disp1 = 0, run2 = 0, disp2 = 0;
  logic clr_n1, shld1, j1, kn1, cclk1, qn1, done1, rslt1;
  logic clr_n2, shld2, j2, kn2, cclk2, qn2, done2, rslt2;
  logic [3:0] par1, q1;
  logic [7:0] par2, q2;
  bit   [3:0] cq1;
  bit   [7:0] cq2;
  bit   stuck = 0;
  int   cyc = 0, nchk = 0, nfail = 0, start1 = 0, start2 = 0, idx1 = 0, idx2 = 0;
  bit   dprev1 = 0, dprev2 = 0;
  exp_t sb1[$], sb2[$];
`ifdef SHREG_FAIL_CAPTURE_EN
  logic [7:0] fidx1;
  logic [4:0] fexp1, fobs1;
  logic [4:0] fidx2;
  logic [8:0] fexp2, fobs2;
`endif

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  shreg_chip_checker #(.WIDTH(4), .SETTLE_CYCLES(S), .NUM_VECTORS(NV1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Run(run1), .DISP_RSLT(disp1), .CLR_N_OUT(clr_n1),
    .SHLD_N_OUT(shld1), .J_OUT(j1), .KN_OUT(kn1), .PAR_OUT(par1), .CHIP_CLK(cclk1),
    .Q_IN(q1), .QN_IN(qn1), .Done(done1), .RSLT(rslt1)
`ifdef SHREG_FAIL_CAPTURE_EN
    , .FAIL_IDX(fidx1), .FAIL_EXP(fexp1), .FAIL_OBS(fobs1)
`endif
  );

  shreg_chip_checker #(.WIDTH(8), .SETTLE_CYCLES(S), .NUM_VECTORS(NV2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Run(run2), .DISP_RSLT(disp2), .CLR_N_OUT(clr_n2),
    .SHLD_N_OUT(shld2), .J_OUT(j2), .KN_OUT(kn2), .PAR_OUT(par2), .CHIP_CLK(cclk2),
    .Q_IN(q2), .QN_IN(qn2), .Done(done2), .RSLT(rslt2)
`ifdef SHREG_FAIL_CAPTURE_EN
    , .FAIL_IDX(fidx2), .FAIL_EXP(fexp2), .FAIL_OBS(fobs2)
`endif
  );

  function automatic bit nqa(bit j, bit kn, bit qa);
    case ({j, kn})
      2'b00:   return 1'b0;
      2'b11:   return 1'b1;
      2'b01:   return qa;
      default: return ~qa;
    endcase
  endfunction

  // Behavioural parts under test; stuck forces chip 1's QA output low.
  always @(posedge cclk1 or negedge clr_n1)
    if (!clr_n1)     cq1 <= '0;
    else if (!shld1) cq1 <= par1;
    else             cq1 <= {cq1[2:0], nqa(j1, kn1, cq1[0])};
  assign q1  = stuck ? {cq1[3:1], 1'b0} : cq1;
  assign qn1 = ~cq1[3];

  always @(posedge cclk2 or negedge clr_n2)
    if (!clr_n2)     cq2 <= '0;
    else if (!shld2) cq2 <= par2;
    else             cq2 <= {cq2[6:0], nqa(j2, kn2, cq2[0])};
  assign q2  = cq2;
  assign qn2 = ~cq2[7];

  task automatic check(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Pin sequencing: each chip clock carries stimulus equal to its vector number.
  // Chip state read here is the value before this clock edge.
  always @(posedge cclk1 or negedge clr_n1)
    if (!clr_n1) idx1 <= 0;
    else begin
      check("pins1", int'({par1, j1, kn1, shld1}), idx1);
      if (idx1 == 93) check("load_1011", int'(q1), 4'b1011);
      if (idx1 == 94) check("shift_toggle", int'({qn1, q1}), 5'b10110);
      idx1 <= idx1 + 1;
    end

  always @(posedge cclk2 or negedge clr_n2)
    if (!clr_n2) idx2 <= 0;
    else begin
      check("pins2", int'({par2, j2, kn2, shld2}), idx2);
      idx2 <= idx2 + 1;
    end

  // Scoreboard monitors: pop an expectation on every Done rising edge.
  always @(negedge Clk) begin
    exp_t e;
    if (done1 && !dprev1) begin
      if (sb1.size() == 0) check("sb1_unexpected_done", 1, 0);
      else begin
        e = sb1.pop_front();
        check("rslt1", int'(rslt1), int'(e.rslt));
        check("latency1", cyc - start1, e.lat);
      end
    end
    if (done2 && !dprev2) begin
      if (sb2.size() == 0) check("sb2_unexpected_done", 1, 0);
      else begin
        e = sb2.pop_front();
        check("rslt2", int'(rslt2), int'(e.rslt));
        check("latency2", cyc - start2, e.lat);
      end
    end
    dprev1 = done1;
    dprev2 = done2;
  end

  task automatic run1_test(input bit r, input int lat);
    @(negedge Clk);
    run1   = 1;
    start1 = cyc;
    sb1.push_back('{r, lat});
    for (int i = 0; i < 2000 && !done1; i++) @(negedge Clk);
    check("done1_timeout", int'(done1), 1);
    @(negedge Clk);
  endtask

  task automatic release1();
    @(negedge Clk);
    run1  = 0;
    disp1 = 1;
    @(negedge Clk);
    check("idle_after_disp1", int'(done1), 0);
    disp1 = 0;
    @(negedge Clk);
  endtask

  initial begin
    #12;
    check("rst_clr_n", int'(clr_n1), 1);
    check("rst_shld_n", int'(shld1), 1);
    check("rst_j_kn", int'({j1, kn1}), 0);
    check("rst_par", int'(par1), 0);
    check("rst_chip_clk", int'(cclk1), 0);
    check("rst_done_rslt", int'({done1, rslt1}), 0);
    @(negedge Clk);
    Reset = 1;
    repeat (2) @(negedge Clk);
    check("idle_done", int'(done1), 0);

    // Good chip, full sweep: 1 edge-detect + CLEAR(2) + 128*(SETUP+HI+LO+CHECK).
    run1_test(1, 1 + S + NV1 * (3 * S + 1));
    disp1 = 1;
    repeat (3) @(negedge Clk);
    check("hold_done_run_high", int'(done1), 1);
    run1 = 0;
    @(negedge Clk);
    check("done_drop_run_low", int'(done1), 0);
    disp1 = 0;
    repeat (2) @(negedge Clk);
    check("no_restart", int'(done1 | cclk1), 0);

    // QA stuck low: vector 5 (J=1,K'=0 toggle from 0) is the first to see QA=1.
    stuck = 1;
    run1_test(0, 1 + S + 6 * (3 * S + 1));
`ifdef SHREG_FAIL_CAPTURE_EN
    check("fail_idx", int'(fidx1), 5);
    check("fail_exp", int'(fexp1), 5'b10001);
    check("fail_obs", int'(fobs1), 5'b10000);
`endif
    release1();
`ifdef SHREG_FAIL_CAPTURE_EN
    check("fail_idx_cleared", int'(fidx1), 0);
`endif
    stuck = 0;

    // Reset asserted during CLK_HI, then a clean restart from vector 0.
    @(negedge Clk);
    run1 = 1;
    for (int i = 0; i < 200 && !cclk1; i++) @(negedge Clk);
    check("reached_clk_hi", int'(cclk1), 1);
    #2 Reset = 0;
    #1;
    check("async_chip_clk", int'(cclk1), 0);
    check("async_clr_n", int'(clr_n1), 1);
    check("async_done", int'(done1), 0);
    @(negedge Clk);
    run1 = 0;
    Reset = 1;
    repeat (2) @(negedge Clk);
    run1_test(1, 1 + S + NV1 * (3 * S + 1));
    release1();

    // Wide part, short sweep: only low four stimulus bits ever toggle.
    @(negedge Clk);
    run2   = 1;
    start2 = cyc;
    sb2.push_back('{1'b1, 1 + S + NV2 * (3 * S + 1)});
    for (int i = 0; i < 500 && !done2; i++) @(negedge Clk);
    check("done2_timeout", int'(done2), 1);
    @(negedge Clk);
    check("sb_drained", sb1.size() + sb2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
